// File: rtl/reg_ctl_pkg.sv
// Shared types and constants for the frame-paced register button controller.
package reg_ctl_pkg;

    // Auto-repeat state machine states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_e;

    // Debounced button command / latched step direction
    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_e;

    // Default parameter values
    localparam logic [7:0] DEF_RESET_VALUE     = 8'd0;
    localparam int         DEF_DEBOUNCE_FRAMES = 2;
    localparam int         DEF_REPEAT_DELAY    = 30;
    localparam int         DEF_REPEAT_RATE     = 4;
    localparam bit         DEF_BTN_ACTIVE_LOW  = 1'b1;

    // Counter widths: debounce counts up to 15 frames, repeat counter up to 255
    localparam int DEB_CNT_W = 4;
    localparam int RPT_CNT_W = 8;

    // Exactly one debounced button yields a command; both pressed cancels out
    function automatic dir_e decode_cmd(input logic up, input logic down);
        if (up && !down) begin
            return DIR_UP;
        end else if (down && !up) begin
            return DIR_DOWN;
        end
        return DIR_NONE;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-FF synchroniser, polarity normalisation and a
// frame-tick-gated debounce counter. deb is the accepted pressed level.
module btn_debounce
    import reg_ctl_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES,
    parameter bit BTN_ACTIVE_LOW  = DEF_BTN_ACTIVE_LOW
) (
    input  logic px_clk,
    input  logic reset_n,
    input  logic tick,
    input  logic btn_raw,
    output logic deb
);

    localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEBOUNCE_FRAMES - 1);

    logic                 sync_1;
    logic                 sync_2;
    logic                 pressed;
    logic [DEB_CNT_W-1:0] cnt;

    // Synchroniser; resets to the idle (not pressed) raw level
    always_ff @(posedge px_clk) begin
        if (!reset_n) begin
            sync_1 <= BTN_ACTIVE_LOW;
            sync_2 <= BTN_ACTIVE_LOW;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end

    assign pressed = BTN_ACTIVE_LOW ? ~sync_2 : sync_2;

    // Accept a new level only after it has been seen on DEBOUNCE_FRAMES ticks
    always_ff @(posedge px_clk) begin
        if (!reset_n) begin
            cnt <= '0;
            deb <= 1'b0;
        end else if (tick) begin
            if (pressed == deb) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                deb <= pressed;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_button_ctl.sv
// Frame-paced up/down button controller driving the 8-bit register value
// shown by the VGA register display. Single step on press, then auto-repeat.
// Build option: REG_WRAP_EN defined -> value wraps at 255/0;
// undefined -> value saturates at 255/0 (no changed pulse on a clipped step).
module reg_button_ctl
    import reg_ctl_pkg::*;
#(
    parameter logic [7:0] RESET_VALUE     = DEF_RESET_VALUE,
    parameter int         DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES,
    parameter int         REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int         REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter bit         BTN_ACTIVE_LOW  = DEF_BTN_ACTIVE_LOW
) (
    input  logic       px_clk,
    input  logic       reset_n,
    input  logic       endframe,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [7:0] register,
    output logic       changed
);

    localparam logic [RPT_CNT_W-1:0] DELAY_LAST = RPT_CNT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_CNT_W-1:0] RATE_LAST  = RPT_CNT_W'(REPEAT_RATE - 1);

    logic                 endframe_d;
    logic                 tick;
    logic [1:0]           btn_raw;
    logic [1:0]           deb;
    dir_e                 cmd;
    dir_e                 cur_dir;
    state_e               state;
    logic [RPT_CNT_W-1:0] rcnt;
    logic [7:0]           step_val;
    logic                 step_diff;

    // Index 0 is the up button, index 1 the down button
    assign btn_raw = {btn_down, btn_up};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
                .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
            ) u_debounce (
                .px_clk  (px_clk),
                .reset_n (reset_n),
                .tick    (tick),
                .btn_raw (btn_raw[gi]),
                .deb     (deb[gi])
            );
        end
    endgenerate

    // Edge-detect endframe so a long end-of-frame level gives one tick
    always_ff @(posedge px_clk) begin
        if (!reset_n) begin
            endframe_d <= 1'b0;
        end else begin
            endframe_d <= endframe;
        end
    end

    assign tick = endframe & ~endframe_d;

    // Uses deb as it was before this tick's debounce update
    assign cmd = decode_cmd(deb[0], deb[1]);

    // Candidate next value for a step in the current command direction
    always_comb begin
        step_val = register;
        if (cmd == DIR_UP) begin
`ifdef REG_WRAP_EN
            step_val = register + 8'd1;
`else
            step_val = (register == 8'hFF) ? register : register + 8'd1;
`endif
        end else if (cmd == DIR_DOWN) begin
`ifdef REG_WRAP_EN
            step_val = register - 8'd1;
`else
            step_val = (register == 8'h00) ? register : register - 8'd1;
`endif
        end
    end

    assign step_diff = (step_val != register);

    // Step / auto-repeat state machine with registered value and pulse
    always_ff @(posedge px_clk) begin
        changed <= 1'b0;
        if (!reset_n) begin
            register <= RESET_VALUE;
            state    <= IDLE;
            cur_dir  <= DIR_NONE;
            rcnt     <= '0;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (cmd != DIR_NONE) begin
                        register <= step_val;
                        changed  <= step_diff;
                        cur_dir  <= cmd;
                        rcnt     <= '0;
                        state    <= DELAY;
                    end
                end
                DELAY: begin
                    if (cmd != cur_dir) begin
                        state <= IDLE;
                    end else if (rcnt == DELAY_LAST) begin
                        register <= step_val;
                        changed  <= step_diff;
                        rcnt     <= '0;
                        state    <= REPEAT;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                REPEAT: begin
                    if (cmd != cur_dir) begin
                        state <= IDLE;
                    end else if (rcnt == RATE_LAST) begin
                        register <= step_val;
                        changed  <= step_diff;
                        rcnt     <= '0;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_button_ctl.sv
// Scoreboard bench for reg_button_ctl: each button hold pushes the expected
// (tick, value) steps; a monitor pops one entry per changed pulse.
module tb_reg_button_ctl;
    import reg_ctl_pkg::*;

    localparam int N = 2;    // debounce frames
    localparam int D = 30;   // repeat delay
    localparam int R = 4;    // repeat rate

    logic       px_clk   = 1'b0;
    logic       reset_n  = 1'b0;
    logic       endframe = 1'b0;
    logic       btn_up   = 1'b1;
    logic       btn_down = 1'b1;
    logic [7:0] register;
    logic       changed;
    logic [7:0] register_b;
    logic       changed_b;

    always #5 px_clk = ~px_clk;

    reg_button_ctl dut (
        .px_clk   (px_clk),
        .reset_n  (reset_n),
        .endframe (endframe),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .register (register),
        .changed  (changed)
    );

    reg_button_ctl #(.RESET_VALUE(8'd100)) dut_b (
        .px_clk   (px_clk),
        .reset_n  (reset_n),
        .endframe (endframe),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .register (register_b),
        .changed  (changed_b)
    );

    typedef struct {
        string      tag;
        int         tick;
        logic [7:0] val;
    } exp_t;

    exp_t       exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         tick_no  = 0;
    logic [7:0] exp_reg  = 8'd0;

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        if (obs != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] model_step(input logic [7:0] v, input bit up);
`ifdef REG_WRAP_EN
        return up ? v + 8'd1 : v - 8'd1;
`else
        if (up) return (v == 8'hFF) ? v : v + 8'd1;
        return (v == 8'h00) ? v : v - 8'd1;
`endif
    endfunction

    // Steps for a button held over ticks 1..hold: first at N+1, then
    // +D, then every R, continuing until the released level is debounced.
    task automatic push_schedule(input string tag, input bit up, input int hold);
        int         t;
        bit         first;
        logic [7:0] nv;
        exp_t       e;
        if (hold < N) return;
        t     = N + 1;
        first = 1'b1;
        while (t <= hold + N) begin
            nv = model_step(exp_reg, up);
            if (nv != exp_reg) begin
                e.tag  = tag;
                e.tick = t;
                e.val  = nv;
                exp_q.push_back(e);
            end
            exp_reg = nv;
            t       = t + (first ? D : R);
            first   = 1'b0;
        end
    endtask

    // One frame: endframe low for lo cycles then high for hi cycles
    task automatic frame(input int hi, input int lo);
        endframe = 1'b0;
        repeat (lo) @(negedge px_clk);
        endframe = 1'b1;
        tick_no++;
        repeat (hi) @(negedge px_clk);
    endtask

    task automatic run_hold(input string tag, input bit up, input bit down,
                            input int hold, input int hi, input int lo);
        tick_no = 0;
        if (up ^ down) push_schedule(tag, up, hold);
        btn_up   = ~up;
        btn_down = ~down;
        repeat (hold) frame(hi, lo);
        btn_up   = 1'b1;
        btn_down = 1'b1;
        repeat (N + 3) frame(hi, lo);
        endframe = 1'b0;
        repeat (3) @(negedge px_clk);
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_reg"}, int'(register), int'(exp_reg));
        exp_q.delete();
    endtask

    // Monitor: every changed pulse must match the next scoreboard entry
    initial begin
        forever begin
            @(posedge px_clk);
            #1;
            if (changed) begin
                if (exp_q.size() == 0) begin
                    check("spurious_pulse", int'(changed), 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("step %s tick=%0d reg=%0d", e.tag, tick_no, register);
                    check({e.tag, "_tick"}, tick_no, e.tick);
                    check({e.tag, "_val"}, int'(register), int'(e.val));
                end
            end
        end
    end

    initial begin
        // Reset held for three cycles
        @(negedge px_clk);
        reset_n = 1'b0;
        repeat (3) @(posedge px_clk);
        #1;
        check("rst_reg", int'(register), 0);
        check("rst_changed", int'(changed), 0);
        check("rst_reg_b", int'(register_b), 100);
        check("rst_changed_b", int'(changed_b), 0);
        @(negedge px_clk);
        reset_n = 1'b1;
        exp_reg = 8'd0;
        repeat (4) @(negedge px_clk);

        run_hold("single_up",   1'b1, 1'b0, 3,  1, 5);
        run_hold("climb_up",    1'b1, 1'b0, 61, 1, 5);
        run_hold("repeat_down", 1'b0, 1'b1, 45, 1, 5);
        run_hold("glitch_up",   1'b1, 1'b0, 1,  1, 5);
        run_hold("both_held",   1'b1, 1'b1, 40, 1, 5);
        run_hold("to_zero",     1'b0, 1'b1, 45, 1, 5);
        run_hold("down_at_0",   1'b0, 1'b1, 3,  1, 5);
        if (exp_reg == 8'd0) run_hold("climb_255", 1'b1, 1'b0, 1045, 1, 5);
        run_hold("up_at_255",   1'b1, 1'b0, 3,  1, 5);
        run_hold("long_ef",     1'b0, 1'b1, 3,  50, 4);

        // Reset in the middle of auto-repeat with the button still held
        tick_no = 0;
        push_schedule("rst_rpt", 1'b0, 38);
        btn_down = 1'b0;
        repeat (38) frame(50, 4);
        endframe = 1'b0;
        @(negedge px_clk);
        reset_n = 1'b0;
        @(posedge px_clk);
        #1;
        check("rst_rpt_pending", exp_q.size(), 0);
        check("rst_rpt_reg", int'(register), 0);
        check("rst_rpt_changed", int'(changed), 0);
        check("rst_rpt_state", int'(dut.state), int'(IDLE));
        check("rst_rpt_reg_b", int'(register_b), 100);
        exp_q.delete();
        exp_reg = 8'd0;
        @(negedge px_clk);
        reset_n = 1'b1;
        run_hold("post_rst", 1'b0, 1'b1, 5, 1, 5);
        check("post_rst_state", int'(dut.state), int'(IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
